// File: rtl/alu_multiword_ctrl.sv
// Word-serial sequencer that runs WORDS*N-bit operations through one N-bit ALU,
// least-significant word first, chaining carry/borrow between words.
module alu_multiword_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cb_in_init,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   result,
  output logic                 cb_out,
  output logic [2:0]           alu_mode,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_cb_in,
  input  logic [N-1:0]         alu_result,
  input  logic                 alu_cb_out
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_INC = 3'b110;
  localparam logic [2:0] MODE_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      mode_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            chain_q;
  logic [IW-1:0]   idx_q;

  logic            arith_c;
  logic            last_c;
  logic            start_cb_c;

  // Arithmetic modes propagate a carry/borrow chain; logic modes do not.
  assign arith_c    = (mode_q == MODE_ADD) || (mode_q == MODE_SUB) ||
                      (mode_q == MODE_INC) || (mode_q == MODE_DEC);
  assign last_c     = (idx_q == IW'(WORDS - 1));
  // Initial chain value: caller's carry for add/sub, forced 1 for inc/dec.
  assign start_cb_c = ((mode == MODE_ADD) || (mode == MODE_SUB)) ? cb_in_init :
                      ((mode == MODE_INC) || (mode == MODE_DEC)) ? 1'b1 : 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = last_c ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, ALU drive, slice capture and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      chain_q   <= 1'b0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cb_out    <= 1'b0;
      alu_mode  <= 3'b000;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cb_in <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            a_q     <= op_a;
            b_q     <= op_b;
            chain_q <= start_cb_c;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        ISSUE: begin
          alu_a <= a_q[idx_q*N +: N];
          case (mode_q)
            MODE_INC: begin
              alu_mode <= MODE_ADD;
              alu_b    <= '0;
            end
            MODE_DEC: begin
              alu_mode <= MODE_SUB;
              alu_b    <= '0;
            end
            default: begin
              alu_mode <= mode_q;
              alu_b    <= b_q[idx_q*N +: N];
            end
          endcase
          alu_cb_in <= arith_c & chain_q;
        end
        CAPTURE: begin
          result[idx_q*N +: N] <= alu_result;
          chain_q              <= arith_c & alu_cb_out;
          if (last_c) begin
            // Publish final carry together with the done pulse.
            cb_out <= arith_c & alu_cb_out;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiword_ctrl.sv
// Bench for alu_multiword_ctrl: attached N-bit ALU model, wide-arithmetic
// reference model with per-cycle compare, plus directed literal checks.
module tb_alu_multiword_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     mode;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           cb_in_init;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           cb_out;
  logic [2:0]     alu_mode;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic           alu_cb_in;
  logic [N-1:0]   alu_result;
  logic           alu_cb_out;

  int tests = 0;
  int fails = 0;

  alu_multiword_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .cb_in_init(cb_in_init), .busy(busy), .done(done), .result(result),
    .cb_out(cb_out), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cb_in(alu_cb_in), .alu_result(alu_result), .alu_cb_out(alu_cb_out)
  );

  always #5 clk = ~clk;

  // Narrow combinational ALU the sequencer drives.
  always_comb begin
    {alu_cb_out, alu_result} = '0;
    case (alu_mode)
      3'b000: {alu_cb_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + (N+1)'(alu_cb_in);
      3'b001: {alu_cb_out, alu_result} = {1'b0, alu_a} - {1'b0, alu_b} - (N+1)'(alu_cb_in);
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~alu_a;
      3'b110: {alu_cb_out, alu_result} = {1'b0, alu_a} + (N+1)'(1);
      default: {alu_cb_out, alu_result} = {1'b0, alu_a} - (N+1)'(1);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: {carry/borrow, result} of the wide operation.
  function automatic logic [W:0] wide_model(input logic [2:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic ci);
    case (m)
      3'b000: return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      3'b001: return {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      3'b010: return {1'b0, a & b};
      3'b011: return {1'b0, a | b};
      3'b100: return {1'b0, a ^ b};
      3'b101: return {1'b0, ~a};
      3'b110: return {1'b0, a} + (W+1)'(1);
      default: return {1'b0, a} - (W+1)'(1);
    endcase
  endfunction

  // Timeline model: an accepted op is busy for 2*WORDS cycles, then one done cycle.
  int           cyc = 0;
  int           m_acc = 0;
  bit           m_active = 1'b0;
  logic [W:0]   m_pend;
  logic [W-1:0] m_result = '0;
  logic         m_cb = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_en   = 1'b1;
      m_active = 1'b0;
      m_result = '0;
      m_cb     = 1'b0;
    end else begin
      if (start && (!m_active || (cyc - m_acc) >= int'(2*WORDS + 2))) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_pend   = wide_model(mode, op_a, op_b, cb_in_init);
      end
      if (m_active && (cyc - m_acc) == int'(2*WORDS)) begin
        m_result = m_pend[W-1:0];
        m_cb     = m_pend[W];
      end
    end
  end

  int e_age;
  bit e_busy;
  bit e_done;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_age  = cyc - m_acc;
      e_busy = m_active && e_age < int'(2*WORDS);
      e_done = m_active && e_age == int'(2*WORDS);
      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      if (!e_busy) begin
        check("result", 64'(result), 64'(m_result));
        check("cb_out", 64'(cb_out), 64'(m_cb));
      end
    end
  end

  // One wide op with literal expectations on latency, busy span, result and cb_out.
  task automatic run_op(input string name, input logic [2:0] m, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] exp_r, input logic exp_c);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    mode = m; op_a = a; op_b = b; cb_in_init = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = ~a; op_b = ~b; cb_in_init = ~ci; mode = ~m;
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      edges++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({name, " done_seen"}, 64'(seen), 64'(1));
    check({name, " latency"}, 64'(edges), 64'(8));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(8));
    check({name, " result"}, 64'(result), 64'(exp_r));
    check({name, " cb_out"}, 64'(cb_out), 64'(exp_c));
    @(posedge clk); #1;
    check({name, " done_pulse_width"}, 64'(done), 64'(0));
  endtask

  int dcount;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'b000; op_a = '0; op_b = '0; cb_in_init = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst result", 64'(result), 64'(0));
    check("rst cb_out", 64'(cb_out), 64'(0));
    check("rst alu_mode", 64'(alu_mode), 64'(0));
    check("rst alu_a", 64'(alu_a), 64'(0));
    check("rst alu_b", 64'(alu_b), 64'(0));
    check("rst alu_cb_in", 64'(alu_cb_in), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add",       3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_op("add_ovf",   3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("add_cin",   3'b000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    run_op("sub_brw",   3'b001, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op("sub_chain", 3'b001, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0);
    run_op("sub_bin",   3'b001, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0);
    run_op("inc",       3'b110, 16'h0FFF, 16'h5A5A, 1'b0, 16'h1000, 1'b0);
    run_op("inc_wrap",  3'b110, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b1);
    run_op("dec_wrap",  3'b111, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("xor",       3'b100, 16'hF0F0, 16'hFFFF, 1'b1, 16'h0F0F, 1'b0);
    run_op("not",       3'b101, 16'h1234, 16'hFFFF, 1'b1, 16'hEDCB, 1'b0);
    run_op("and",       3'b010, 16'h00FF, 16'h0F0F, 1'b1, 16'h000F, 1'b0);
    run_op("or",        3'b011, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0);

    // Second start three cycles into an operation must be ignored.
    @(negedge clk);
    mode = 3'b000; op_a = 16'h1111; op_b = 16'h2222; cb_in_init = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mode = 3'b001; op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("ignore_start done_count", 64'(dcount), 64'(1));
    check("ignore_start result", 64'(result), 64'(16'h3333));
    check("ignore_start cb_out", 64'(cb_out), 64'(0));

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    mode = 3'b000; op_a = 16'h00FF; op_b = 16'h0001; cb_in_init = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort result", 64'(result), 64'(0));
    check("abort cb_out", 64'(cb_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("abort done_count", 64'(dcount), 64'(0));

    run_op("after_abort", 3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
